clkdiv_ctrl: RTL
================

Name: clkdiv_ctrl

Overview:
- Run-time programmable clock divider controller for the LED-driver clock domain: generates a divided clock `o_clk` from `i_clk`, with start/stop sequencing.
- The divide ratio is reconfigured through a valid/ready handshake.
- Ratio changes, starts and stops only ever occur on full half-period boundaries, so `o_clk` never shows a runt pulse.
- Downstream shift/latch logic consumes the `o_rise`/`o_fall` strobes as clock enables in the `i_clk` domain.

Parameters:
- c_width, 8, bit width of the half-period count (maximum half-period 2^c_width-1 input cycles).
- c_div_init, 4, divide ratio after reset; must be even and >= 2; reset half-period = c_div_init/2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_run  in  1  level; 1 = divided clock runs, 0 = stop after the current period completes.
- i_cfg_valid  in  1  new half-period offered.
- i_cfg_half  in  c_width  requested half-period in i_clk cycles (divide = 2*value).
- o_cfg_ready  out  1  config accepted when valid&ready at a rising edge.
- o_cfg_err  out  1  one-cycle pulse: accepted value was 0 and is discarded.
- o_clk  out  1  divided clock, registered.
- o_rise  out  1  high during the first i_clk cycle in which o_clk=1.
- o_fall  out  1  high during the first i_clk cycle in which o_clk=0 after a high half.
- o_busy  out  1  1 while not IDLE.
- o_half  out  c_width  half-period currently in effect.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, r_count=0, o_clk=0, o_rise=0, o_fall=0, o_cfg_err=0, o_busy=0.
  - o_half=c_div_init/2, pending flag=0, o_cfg_ready=1.
- States:
  - IDLE: counter held at 0, o_clk=0.
  - RUN: counting.
  - STOPPING: i_run seen low, finishing the period.
- Counter core: each RUN/STOPPING cycle, r_count increments. When r_count==o_half-1: r_count<=0 and o_clk toggles. The width is c_width; no wrap beyond o_half-1.
- Start:
  - In IDLE, i_run=1 at edge E0 moves to RUN with r_count=0 and o_clk=0.
  - The low half is first: o_clk rises after edge E0+h, where h=o_half.
- Stop:
  - i_run=0 in RUN moves to STOPPING.
  - If o_clk=1: complete the high half, toggle to 0, then complete a full low half.
  - If o_clk=0: complete the current low half.
  - At that low-half terminal count, go to IDLE instead of toggling high; o_clk stays 0.
  - i_run returning to 1 during STOPPING cancels the stop: back to RUN with no phase disturbance.
- Config handshake:
  - o_cfg_ready=1 whenever no config is pending.
  - Accept: value 0 pulses o_cfg_err the next cycle with no other effect. A nonzero value is stored as pending, and ready drops to 0.
  - In IDLE, a pending value is applied on the next edge.
  - In RUN/STOPPING, a pending value is applied at the edge where o_clk toggles 1->0; the new low half already uses the new value. Both halves of every period therefore use one value.
  - On entering IDLE, any pending value is applied on that same edge.
  - o_cfg_ready returns to 1 the cycle after the value is applied.
- Simultaneous events: cfg accept and stop in the same cycle are both honoured. Application follows the rules above.
- Strobes: o_rise and o_fall are registered. Each is exactly one cycle wide, aligned to the first cycle of the new o_clk level. Neither pulses in IDLE.
- Minimum half-period is 1, giving divide-by-2.

Decomposition:
- Package clkdiv_pkg contains:
  - state encoding (IDLE, RUN, STOPPING);
  - constant c_half_min=1;
  - function computing the reset half-period from c_div_init.
- Sub-module clkdiv_core holds the half-period counter and toggle register. Its inputs are enable, half and clear; its outputs are terminal-count, clk and the rise/fall strobes.
- The FSM and the config holding register stay in clkdiv_ctrl.

Test Plan:
- Reset, i_run=1 from E0, default c_div_init=4 -> o_clk low for 2 cycles, rises after E2, then period 4. o_rise and o_fall each pulse once per period, 1 cycle wide.
- While running h=2 with o_clk high, offer i_cfg_half=5 -> ready drops. The current high half stays 2 cycles. The following low and high halves are 5 each. o_half becomes 5 at the falling edge, and ready returns the next cycle.
- Drop i_run during the first cycle of a high half (h=3) -> 2 more high cycles, a full 3-cycle low, then IDLE. o_busy=0, o_clk=0, and no further o_rise.
- Offer i_cfg_half=0 -> o_cfg_err pulses 1 cycle, o_half unchanged, ready stays 1, and the period is undisturbed.
- Assert i_rst mid high half, between clock edges -> o_clk=0, o_busy=0 and o_half=2 immediately, with no clock edge needed.
- In IDLE, write half=1, then i_run=1 -> divide-by-2 (o_clk toggles every cycle), with o_rise and o_fall alternating every cycle.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clkdiv_pkg;

    // Controller states: stopped, dividing, or finishing the last period.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    // Smallest legal half-period (divide-by-2).
    localparam int c_half_min = 1;

    // Half-period that corresponds to a full divide ratio.
    function automatic int half_from_div(input int div_ratio);
        return div_ratio / 2;
    endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Half-period counter and toggle register for the divided clock.
// The divided clock toggles whenever the count reaches half-1, and the
// rise/fall strobes mark the first cycle of each new level.
module clkdiv_core #(
    parameter int c_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [c_width-1:0] half,
    output logic               tc,
    output logic               div_clk,
    output logic               rise,
    output logic               fall
);

    logic [c_width-1:0] count;

    assign tc = (count == (half - c_width'(1)));

    // Count within the current half and toggle at its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            count   <= '0;
            div_clk <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            div_clk <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (enable) begin
            if (tc) begin
                count   <= '0;
                div_clk <= ~div_clk;
                rise    <= ~div_clk;
                fall    <= div_clk;
            end else begin
                count <= count + c_width'(1);
                rise  <= 1'b0;
                fall  <= 1'b0;
            end
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time programmable clock divider controller with glitch-free
// start/stop sequencing and a valid/ready half-period reconfiguration port.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int c_width    = 8,
    parameter int c_div_init = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_cfg_valid,
    input  logic [c_width-1:0] i_cfg_half,
    output logic               o_cfg_ready,
    output logic               o_cfg_err,
    output logic               o_clk,
    output logic               o_rise,
    output logic               o_fall,
    output logic               o_busy,
    output logic [c_width-1:0] o_half
);

    localparam logic [c_width-1:0] c_half_rst = c_width'(half_from_div(c_div_init));
    localparam logic [c_width-1:0] c_half_lo  = c_width'(c_half_min);

    state_t             state;
    state_t             state_next;
    logic               core_enable;
    logic               core_clear;
    logic               core_tc;
    logic               enter_idle;
    logic               accept;
    logic               apply;
    logic               pend;
    logic [c_width-1:0] pend_val;

    clkdiv_core #(.c_width(c_width)) u_core (
        .clk     (i_clk),
        .rst     (i_rst),
        .enable  (core_enable),
        .clear   (core_clear),
        .half    (o_half),
        .tc      (core_tc),
        .div_clk (o_clk),
        .rise    (o_rise),
        .fall    (o_fall)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and core control; a stop only completes at the end of a low half.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        core_enable = 1'b0;
        core_clear  = 1'b0;
        enter_idle  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                core_clear = 1'b1;
                if (i_run) state_next = ST_RUN;
            end
            ST_RUN: begin
                core_enable = 1'b1;
                if (!i_run) state_next = ST_STOPPING;
            end
            ST_STOPPING: begin
                core_enable = 1'b1;
                if (i_run) begin
                    state_next = ST_RUN;
                end else if (core_tc && !o_clk) begin
                    state_next = ST_IDLE;
                    core_clear = 1'b1;
                    enter_idle = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept = i_cfg_valid & o_cfg_ready;
    // A pending half is only taken where no half-period is in progress:
    // in IDLE, on entering IDLE, or as the high half ends.
    assign apply  = pend & ((state == ST_IDLE) | enter_idle |
                            (core_enable & core_tc & o_clk));
    assign o_busy = (state != ST_IDLE);

    // Config holding register, error pulse and ready handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend        <= 1'b0;
            pend_val    <= '0;
            o_half      <= c_half_rst;
            o_cfg_ready <= 1'b1;
            o_cfg_err   <= 1'b0;
        end else begin
            o_cfg_err <= 1'b0;
            if (accept) begin
                if (i_cfg_half < c_half_lo) begin
                    o_cfg_err <= 1'b1;
                end else begin
                    pend        <= 1'b1;
                    pend_val    <= i_cfg_half;
                    o_cfg_ready <= 1'b0;
                end
            end else if (apply) begin
                o_half <= pend_val;
                pend   <= 1'b0;
            end else if (!pend && !o_cfg_ready) begin
                o_cfg_ready <= 1'b1;
            end
        end
    end

endmodule
